// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between cpu_top and cpu_run_ctrl: requests in, pipeline controls and status out.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             enable;
    logic             start;
    logic             halt_req;
    logic             stall_in;
    logic             pipe_en;
    logic             pipe_flush;
    logic             pc_clear;
    logic             pc_we;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [2:0]       state_o;

    modport master (
        output enable, start, halt_req, stall_in,
        input  pipe_en, pipe_flush, pc_clear, pc_we, running, halted, cycle_count, state_o
    );

    modport slave (
        input  enable, start, halt_req, stall_in,
        output pipe_en, pipe_flush, pc_clear, pc_we, running, halted, cycle_count, state_o
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: start-edge flush, free run, halt drain and halted state,
// plus a saturating count of enabled RUN/DRAIN cycles.
module cpu_run_ctrl #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic           clock,
    input  logic           reset,
    cpu_run_ctrl_if.slave  bus
);
    localparam int unsigned STEP_W     = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned FLUSH_LAST = STAGES - 1;
    localparam int unsigned DRAIN_LAST = (STAGES >= 2) ? STAGES - 2 : 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t             state, state_d;
    logic               start_q;
    logic [STEP_W-1:0]  step, step_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               start_pulse;
    logic [CNT_W-1:0]   cnt_inc;

    assign start_pulse = bus.start & ~start_q;
    // Saturate instead of wrapping so a long run never reads as a short one
    assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            step    <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            start_q <= bus.start;
            step    <= step_d;
            cnt     <= cnt_d;
        end
    end

    // Next state; start_pulse overrides everything, enable=0 freezes progress
    always_comb begin
        state_d = state;
        step_d  = step;
        cnt_d   = cnt;
        if (start_pulse) begin
            state_d = FLUSH;
            step_d  = '0;
        end else if (bus.enable) begin
            unique case (state)
                IDLE: ;
                FLUSH: begin
                    if (step == STEP_W'(FLUSH_LAST)) begin
                        state_d = RUN;
                        step_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        step_d = step + STEP_W'(1);
                    end
                end
                RUN: begin
                    cnt_d = cnt_inc;
                    if (bus.halt_req) begin
                        state_d = DRAIN;
                        step_d  = '0;
                    end
                end
                DRAIN: begin
                    cnt_d = cnt_inc;
                    if (step == STEP_W'(DRAIN_LAST)) begin
                        state_d = HALTED;
                        step_d  = '0;
                    end else begin
                        step_d = step + STEP_W'(1);
                    end
                end
                HALTED: ;
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Moore decode; only pipe_en and pc_we look at enable/stall_in
    always_comb begin
        bus.pipe_en    = 1'b0;
        bus.pipe_flush = 1'b0;
        bus.pc_clear   = 1'b0;
        bus.pc_we      = 1'b0;
        bus.running    = 1'b0;
        bus.halted     = 1'b0;
        unique case (state)
            IDLE: ;
            FLUSH: begin
                bus.pipe_flush = 1'b1;
                bus.pc_clear   = 1'b1;
                bus.pipe_en    = bus.enable;
            end
            RUN: begin
                bus.pipe_en = bus.enable;
                bus.pc_we   = bus.enable & ~bus.stall_in;
                bus.running = 1'b1;
            end
            DRAIN: begin
                bus.pipe_en = bus.enable;
                bus.running = 1'b1;
            end
            HALTED: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.cycle_count = cnt;
    assign bus.state_o     = state;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed vector table plus randomized traffic against a countdown model,
// driving a 32-bit and a 4-bit counter instance in lockstep.
module tb_cpu_run_ctrl;
    localparam int unsigned STAGES = 5;
    localparam longint      MAX_B  = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cpu_run_ctrl_if #(.CNT_W(32)) if_a ();
    cpu_run_ctrl_if #(.CNT_W(4))  if_b ();

    assign if_b.enable   = if_a.enable;
    assign if_b.start    = if_a.start;
    assign if_b.halt_req = if_a.halt_req;
    assign if_b.stall_in = if_a.stall_in;

    cpu_run_ctrl #(.STAGES(STAGES), .CNT_W(32)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
    cpu_run_ctrl #(.STAGES(STAGES), .CNT_W(4))  dut_b (.clock(clock), .reset(reset), .bus(if_b));

    int checks   = 0;
    int failures = 0;

    // Reference model: phase code, cycles left in FLUSH/DRAIN, plain integer counters
    int     m_phase = 0;
    int     m_left  = 0;
    longint m_cnt_a = 0;
    longint m_cnt_b = 0;
    bit     m_sq    = 0;
    bit     m_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s, input bit h);
        bit pulse;
        if (r) begin
            m_phase = 0; m_left = 0; m_cnt_a = 0; m_cnt_b = 0; m_sq = 0; m_valid = 1;
            return;
        end
        pulse = s && !m_sq;
        m_sq  = s;
        if (pulse) begin
            m_phase = 1;
            m_left  = STAGES;
        end else if (e) begin
            if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin m_phase = 2; m_cnt_a = 0; m_cnt_b = 0; end
            end else if (m_phase == 2) begin
                m_cnt_a++;
                if (m_cnt_b < MAX_B) m_cnt_b++;
                if (h) begin m_phase = 3; m_left = STAGES - 1; end
            end else if (m_phase == 3) begin
                m_cnt_a++;
                if (m_cnt_b < MAX_B) m_cnt_b++;
                m_left--;
                if (m_left == 0) m_phase = 4;
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit e, st;
        e  = if_a.enable;
        st = if_a.stall_in;
        chk({tag, " state_a"}, 64'(if_a.state_o), 64'(m_phase));
        chk({tag, " state_b"}, 64'(if_b.state_o), 64'(m_phase));
        chk({tag, " pipe_en"}, 64'(if_a.pipe_en), 64'((m_phase >= 1 && m_phase <= 3) && e));
        chk({tag, " flush"},   64'({if_a.pipe_flush, if_a.pc_clear}), 64'((m_phase == 1) ? 2'b11 : 2'b00));
        chk({tag, " pc_we"},   64'(if_a.pc_we), 64'(m_phase == 2 && e && !st));
        chk({tag, " running"}, 64'(if_a.running), 64'(m_phase == 2 || m_phase == 3));
        chk({tag, " halted"},  64'(if_a.halted), 64'(m_phase == 4));
        chk({tag, " cnt_a"},   64'(if_a.cycle_count), 64'(m_cnt_a));
        chk({tag, " cnt_b"},   64'(if_b.cycle_count), 64'(m_cnt_b));
    endtask

    // One clock: drive at negedge, check settled outputs, then let the edge advance DUT and model
    task automatic cyc(input bit r, input bit e, input bit s, input bit h, input bit st, input string tag);
        @(negedge clock);
        reset         = r;
        if_a.enable   = e;
        if_a.start    = s;
        if_a.halt_req = h;
        if_a.stall_in = st;
        #1;
        if (m_valid) check_model(tag);
        @(posedge clock);
        model_step(r, e, s, h);
    endtask

    typedef struct {
        bit     rst, en, st, halt, stall;
        int     n;
        int     state;
        bit     pc_we, pipe_en, flush, running, halted;
        longint cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit en, bit st, bit halt, bit stall, int n, int state,
                                bit pc_we, bit pipe_en, bit flush, bit running, bit halted, longint cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.st = st; v.halt = halt; v.stall = stall; v.n = n;
        v.state = state; v.pc_we = pc_we; v.pipe_en = pipe_en; v.flush = flush;
        v.running = running; v.halted = halted; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        if_a.enable = 1'b0; if_a.start = 1'b0; if_a.halt_req = 1'b0; if_a.stall_in = 1'b0;

        //            rst en st hl sl  n  st we pe fl rn ht cnt
        vecs.push_back(mk(1, 1, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  4, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 2, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 10, 2, 1, 1, 0, 1, 0, 10));
        vecs.push_back(mk(0, 1, 1, 1, 0,  1, 3, 0, 1, 0, 1, 0, 11));
        vecs.push_back(mk(0, 1, 1, 0, 0,  3, 3, 0, 1, 0, 1, 0, 14));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 4, 0, 0, 0, 0, 1, 15));
        vecs.push_back(mk(0, 1, 1, 0, 0,  3, 4, 0, 0, 0, 0, 1, 15));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 4, 0, 0, 0, 0, 1, 15));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 15));
        vecs.push_back(mk(0, 1, 1, 0, 0,  5, 2, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  2, 2, 1, 1, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 1, 0, 1,  3, 2, 0, 1, 0, 1, 0, 5));
        vecs.push_back(mk(0, 0, 1, 0, 0,  4, 2, 0, 0, 0, 1, 0, 5));
        vecs.push_back(mk(0, 1, 1, 0, 0,  2, 2, 1, 1, 0, 1, 0, 7));
        vecs.push_back(mk(1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  5, 2, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0,  1, 3, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  2, 3, 0, 1, 0, 1, 0, 3));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 3));
        vecs.push_back(mk(0, 1, 1, 0, 0,  5, 2, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 2, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  2, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,  4, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 2, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 2, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0,  1, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,  5, 2, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 20, 2, 1, 1, 0, 1, 0, 20));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 2, 1, 1, 0, 1, 0, 21));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 21));
        vecs.push_back(mk(0, 0, 1, 0, 0,  3, 1, 0, 0, 1, 0, 0, 21));
        vecs.push_back(mk(0, 1, 1, 0, 0,  4, 1, 0, 1, 1, 0, 0, 21));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 2, 1, 1, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            for (int k = 0; k < vecs[i].n; k++)
                cyc(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].halt, vecs[i].stall, tag);
            #1;
            chk({tag, " exp_state"},   64'(if_a.state_o), 64'(vecs[i].state));
            chk({tag, " exp_pc_we"},   64'(if_a.pc_we), 64'(vecs[i].pc_we));
            chk({tag, " exp_pipe_en"}, 64'(if_a.pipe_en), 64'(vecs[i].pipe_en));
            chk({tag, " exp_flush"},   64'({if_a.pipe_flush, if_a.pc_clear}), 64'({vecs[i].flush, vecs[i].flush}));
            chk({tag, " exp_running"}, 64'(if_a.running), 64'(vecs[i].running));
            chk({tag, " exp_halted"},  64'(if_a.halted), 64'(vecs[i].halted));
            chk({tag, " exp_cnt_a"},   64'(if_a.cycle_count), 64'(vecs[i].cnt));
            chk({tag, " exp_cnt_b"},   64'(if_b.cycle_count), 64'((vecs[i].cnt > MAX_B) ? MAX_B : vecs[i].cnt));
        end

        // Randomized traffic: occasional resets, start toggles, halts, stalls and enable drops
        begin
            bit s;
            s = if_a.start;
            for (int k = 0; k < 3000; k++) begin
                bit r, e, h, st;
                r  = ($urandom_range(0, 149) == 0);
                e  = ($urandom_range(0, 7) != 0);
                h  = ($urandom_range(0, 11) == 0);
                st = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 29) == 0) s = ~s;
                cyc(r, e, s, h, st, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Receiving end of the CPU run-control interface (clock, reset, enable, start) inside cpu_top.
- Turns start/enable into pipeline control: a flush sequence on start, then free running, drain on a halt instruction, and a halted state.
- Drives the PC write enable, pipeline-register enables and flush.
- Keeps a cycle counter for the bench.

Parameters:
STAGES, 5, pipeline depth; sets flush length (STAGES cycles) and drain length (STAGES-1 cycles)
CNT_W, 32, width of cycle_count

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high; forces all state to reset values
enable  in  1  global advance qualifier; low freezes flush/run/drain progress
start  in  1  level; a rising edge requests (re)start
halt_req  in  1  from ID stage: halt instruction decoded; sampled only in RUN with enable=1
stall_in  in  1  from hazard unit: hold PC this cycle
pipe_en  out  1  pipeline register enable
pipe_flush  out  1  clear all pipeline registers to bubble
pc_clear  out  1  load PC with reset vector 0
pc_we  out  1  PC write enable
running  out  1  high in RUN or DRAIN
halted  out  1  high in HALTED
cycle_count  out  CNT_W  enabled cycles spent in RUN+DRAIN
state_o  out  3  IDLE=0, FLUSH=1, RUN=2, DRAIN=3, HALTED=4

Behaviour:
- Reset (reset=1 at clock edge):
  - state=IDLE, start_q=0, step counter=0, cycle_count=0.
  - Outputs while in IDLE: all control outputs 0, state_o=0.
- Start edge detect:
  - start_pulse = start & ~start_q; start_q <= start every cycle.
  - start_q resets to 0, so start held high through reset release gives a start_pulse on the first cycle after reset.
- Moore outputs decoded from state. Only pc_we and pipe_en also depend on enable/stall_in.
- IDLE:
  - All outputs 0.
  - start_pulse -> FLUSH with step=0.
- FLUSH:
  - pipe_flush=1, pc_clear=1, pipe_en=enable, pc_we=0.
  - step increments on each cycle with enable=1.
  - When step==STAGES-1 and enable=1 -> RUN, cycle_count<=0.
  - With enable=1 throughout, exactly STAGES cycles.
- RUN:
  - pipe_en=enable, pc_we=enable & ~stall_in, running=1.
  - cycle_count increments when enable=1, saturating at 2^CNT_W-1 (no wrap).
  - halt_req=1 with enable=1 -> DRAIN with step=0. That cycle still counts, and pc_we follows the normal rule.
- DRAIN:
  - pc_we=0, pipe_en=enable, running=1.
  - cycle_count and step increment on enabled cycles.
  - After STAGES-1 enabled cycles (step==STAGES-2 and enable=1) -> HALTED.
  - halt_req is ignored.
- HALTED:
  - halted=1, all enables 0.
  - cycle_count holds its value.
  - start_pulse -> FLUSH.
- Priority, highest first: reset > start_pulse > halt_req > step completion.
  - start_pulse in any state goes to FLUSH, step=0, including mid-FLUSH (flush restarts), RUN and DRAIN.
- enable=0 freezes:
  - step, cycle_count and state (except start_pulse and reset, which act regardless).
  - pc_we=0 and pipe_en=0.
  - pipe_flush and pc_clear stay asserted in FLUSH.
- stall_in only affects pc_we in RUN.
- Simultaneous start_pulse and halt_req in RUN -> FLUSH.
- Reset mid-operation -> IDLE next cycle; a subsequent start edge (or held start) is required to run.
- Width rules:
  - step counter is ceil(log2(STAGES)) bits, minimum 1.
  - cycle_count is unsigned.

Test Plan:
- Reset 2 cycles with start=1 held, enable=1, then release -> cycle 1 FLUSH (state_o=1, pipe_flush=1, pc_clear=1) for exactly 5 cycles, then RUN (state_o=2, pc_we=1, pipe_en=1), cycle_count=0 on entry.
- RUN for 10 cycles, assert halt_req 1 cycle -> DRAIN 4 cycles with pc_we=0, then HALTED (halted=1), cycle_count=15 frozen.
- In RUN drive stall_in=1 for 3 cycles -> pc_we=0, pipe_en=1 those cycles, cycle_count still +3; enable=0 for 4 cycles -> pc_we=0, pipe_en=0, cycle_count unchanged, state stays RUN.
- From HALTED toggle start 0->1 -> FLUSH next cycle, cycle_count cleared on RUN entry; start edge during DRAIN step 2 -> FLUSH, no HALTED.
- Assert reset during RUN at cycle_count=7 -> next cycle IDLE, all outputs 0, cycle_count=0; start held high -> restarts via FLUSH.
- CNT_W=4: run 20 enabled cycles -> cycle_count saturates at 15, no wrap.
